// File: rtl/ring_meas_seq_pkg.sv
// ----------------------------------------------------------------------------
// ring_meas_seq_pkg
// Shared definitions for the ring-oscillator measurement sequencer:
//   - FSM state encoding used by ring_meas_seq
//   - ring-select codes driven to the external counter mux
//   - default width of the ring-counter sample
//   - helper for the number of result bytes sent per measurement
// ----------------------------------------------------------------------------
package ring_meas_seq_pkg;

    // Default width of the Gray-coded ring-counter sample.
    localparam int CNT_W_DEFAULT = 16;

    // Measurement sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_GATE    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_SEND    = 3'd5
    } state_e;

    // Ring-select codes; the enum value is the code on o_ring_sel.
    typedef enum logic [1:0] {
        RING_5  = 2'd0,
        RING_11 = 2'd1,
        RING_23 = 2'd2,
        RING_47 = 2'd3
    } ring_sel_e;

    // Number of bytes needed to carry a sample of the given width.
    function automatic int num_bytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage : ring_meas_seq_pkg

// File: rtl/ring_meas_seq_gray2bin.sv
// ----------------------------------------------------------------------------
// gray2bin
// Purely combinational Gray-to-binary converter, parameterised by width.
//   b[MSB] = g[MSB];  b[k] = b[k+1] ^ g[k]
// Ports:
//   gray  in  pWIDTH  Gray-coded value
//   bin   out pWIDTH  binary equivalent
// ----------------------------------------------------------------------------
module gray2bin #(
    parameter int pWIDTH = 16
) (
    input  logic [pWIDTH-1:0] gray,
    output logic [pWIDTH-1:0] bin
);

    logic acc;

    // NOTE: every variable assigned here gets a value on every pass before it
    // is read, so no latch is inferred; blocking '=' is correct inside
    // combinational logic because later statements must see earlier results.
    always_comb begin
        acc = 1'b0;
        bin = '0;
        // Running XOR from the MSB down: each binary bit is the parity of all
        // Gray bits at and above it.
        for (int k = pWIDTH - 1; k >= 0; k--) begin
            acc    = acc ^ gray[k];
            bin[k] = acc;
        end
    end

endmodule : gray2bin

// File: rtl/ring_meas_seq.sv
// ----------------------------------------------------------------------------
// ring_meas_seq
// Sequencer for one ring-oscillator frequency measurement:
//   IDLE -> CLEAR (1 cycle counter clear) -> GATE (2^win cycles enable)
//   -> SETTLE (pSETTLE cycles) -> CAPTURE (Gray->binary sample)
//   -> SEND (result bytes, MSB first, valid/ack handshake) -> IDLE
// All outputs are registered. Reset is synchronous, active-high.
// Ports:
//   i_clk        in   reference clock
//   i_rst        in   synchronous active-high reset
//   i_start      in   measurement request, honoured only in IDLE
//   i_ring_sel   in   ring to measure (ring_sel_e code)
//   i_win        in   gate window exponent, window = 2^i_win cycles
//   i_cnt_gray   in   Gray-coded ring count, already in the i_clk domain
//   i_ack        in   consumer accepts o_data
//   o_ring_sel   out  latched ring select for the counter mux
//   o_clr        out  one-cycle counter clear
//   o_gate       out  counter enable
//   o_busy       out  high in every state except IDLE
//   o_valid      out  o_data holds a result byte
//   o_data       out  result byte
//   o_last       out  o_data is the least-significant (final) byte
// ----------------------------------------------------------------------------
module ring_meas_seq
    import ring_meas_seq_pkg::*;
#(
    parameter int pCNT_W  = CNT_W_DEFAULT,
    parameter int pSETTLE = 3            // must be >= 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [1:0]        i_ring_sel,
    input  logic [3:0]        i_win,
    input  logic [pCNT_W-1:0] i_cnt_gray,
    input  logic              i_ack,
    output logic [1:0]        o_ring_sel,
    output logic              o_clr,
    output logic              o_gate,
    output logic              o_busy,
    output logic              o_valid,
    output logic [7:0]        o_data,
    output logic              o_last
);

    // Result is sent as whole bytes; a width that is not a byte multiple is
    // zero-padded at the top.
    localparam int NBYTES = num_bytes(pCNT_W);
    localparam int PAD_W  = NBYTES * 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int SET_W  = (pSETTLE > 1) ? $clog2(pSETTLE) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NBYTES - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(pSETTLE - 1);

    state_e              state;
    logic [3:0]          win_q;
    logic [15:0]         gate_cnt;
    logic [15:0]         gate_last;
    logic [SET_W-1:0]    settle_cnt;
    logic [pCNT_W-1:0]   result;
    logic [IDX_W-1:0]    byte_idx;

    logic [pCNT_W-1:0]   cnt_bin;
    logic [PAD_W-1:0]    cnt_bin_pad;
    logic [PAD_W-1:0]    result_pad;

    gray2bin #(
        .pWIDTH (pCNT_W)
    ) u_gray2bin (
        .gray (i_cnt_gray),
        .bin  (cnt_bin)
    );

    assign cnt_bin_pad = PAD_W'(cnt_bin);
    assign result_pad  = PAD_W'(result);

    // Final gate cycle index: 2^win - 1 (at most 32767, fits the 16-bit count).
    assign gate_last = (16'd1 << win_q) - 16'd1;

    // Byte idx of a padded value; idx 0 is the least-significant byte.
    function automatic logic [7:0] byte_of(input logic [PAD_W-1:0] v,
                                           input logic [IDX_W-1:0] idx);
        return v[{idx, 3'b000} +: 8];
    endfunction

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            win_q      <= '0;
            gate_cnt   <= '0;
            settle_cnt <= '0;
            result     <= '0;
            byte_idx   <= '0;
            o_ring_sel <= '0;
            o_clr      <= 1'b0;
            o_gate     <= 1'b0;
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_last     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        o_ring_sel <= i_ring_sel;
                        win_q      <= i_win;
                        o_clr      <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    o_clr    <= 1'b0;
                    o_gate   <= 1'b1;
                    gate_cnt <= '0;
                    state    <= ST_GATE;
                end

                ST_GATE: begin
                    if (gate_cnt == gate_last) begin
                        o_gate     <= 1'b0;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end else begin
                        gate_cnt <= gate_cnt + 16'd1;
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end

                ST_CAPTURE: begin
                    // Present the MSB byte straight from the converter so it
                    // is valid on the same edge that loads the result.
                    result   <= cnt_bin;
                    byte_idx <= LAST_IDX;
                    o_data   <= byte_of(cnt_bin_pad, LAST_IDX);
                    o_last   <= (NBYTES == 1);
                    o_valid  <= 1'b1;
                    state    <= ST_SEND;
                end

                ST_SEND: begin
                    if (i_ack) begin
                        if (byte_idx == '0) begin
                            // A start in this same cycle is dropped: IDLE is
                            // only reached after this edge.
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            o_data  <= '0;
                            o_busy  <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            byte_idx <= byte_idx - IDX_W'(1);
                            o_data   <= byte_of(result_pad, byte_idx - IDX_W'(1));
                            o_last   <= (byte_idx == IDX_W'(1));
                        end
                    end
                end

                default: begin
                    o_clr   <= 1'b0;
                    o_gate  <= 1'b0;
                    o_busy  <= 1'b0;
                    o_valid <= 1'b0;
                    o_last  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : ring_meas_seq

// File: tb/tb_ring_meas_seq.sv
// ----------------------------------------------------------------------------
// tb_ring_meas_seq
// Self-checking bench for ring_meas_seq. A reference model computes the
// expected result bytes from the Gray sample with plain arithmetic and the
// expected phase lengths from the window exponent and settle time.
// ----------------------------------------------------------------------------
module tb_ring_meas_seq;

    localparam int CNT_W  = 16;
    localparam int SETTLE = 3;
    localparam int NB     = (CNT_W + 7) / 8;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_start;
    logic [1:0]       i_ring_sel;
    logic [3:0]       i_win;
    logic [CNT_W-1:0] i_cnt_gray;
    logic             i_ack;
    logic [1:0]       o_ring_sel;
    logic             o_clr;
    logic             o_gate;
    logic             o_busy;
    logic             o_valid;
    logic [7:0]       o_data;
    logic             o_last;

    int n_checks = 0;
    int n_errors = 0;

    ring_meas_seq #(
        .pCNT_W  (CNT_W),
        .pSETTLE (SETTLE)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_ring_sel (i_ring_sel),
        .i_win      (i_win),
        .i_cnt_gray (i_cnt_gray),
        .i_ack      (i_ack),
        .o_ring_sel (o_ring_sel),
        .o_clr      (o_clr),
        .o_gate     (o_gate),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_last     (o_last)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference conversion: binary is the prefix XOR of g, g>>1, g>>2, ...
    function automatic int unsigned gray_to_bin(input int unsigned g);
        int unsigned b = 0;
        for (int s = 0; s < CNT_W; s++) b ^= (g >> s);
        return b & ((32'd1 << CNT_W) - 1);
    endfunction

    // One complete measurement with checking of every phase.
    //   hold0     : cycles i_ack is held low before the first byte
    //   rand_hold : random ack stalls on later bytes (else ack stays high)
    //   noise     : random i_start pulses while busy
    //   start_last: raise i_start with the final acknowledge
    task automatic run_measure(input logic [1:0] sel, input logic [3:0] win,
                               input logic [CNT_W-1:0] gray, input int hold0,
                               input bit rand_hold, input bit noise,
                               input bit start_last);
        int cyc, clr_n, gate_n, gate_rises, sel_bad, fall_at, valid_at;
        int budget, hold, stable_bad;
        logic prev_gate;
        int unsigned b;
        logic [7:0] exp_byte;

        i_cnt_gray = gray;
        @(negedge i_clk);
        i_start    = 1'b1;
        i_ring_sel = sel;
        i_win      = win;
        i_ack      = 1'b0;
        @(negedge i_clk);
        i_start = 1'b0;

        cyc = 0; clr_n = 0; gate_n = 0; gate_rises = 0; sel_bad = 0;
        fall_at = -1; valid_at = -1; prev_gate = 1'b0;
        budget = (1 << win) + SETTLE + 20;
        while (cyc < budget && valid_at < 0) begin
            if (o_clr) clr_n++;
            if (o_gate) gate_n++;
            if (o_gate && !prev_gate) gate_rises++;
            if (!o_gate && prev_gate) fall_at = cyc;
            if (o_ring_sel !== sel || o_busy !== 1'b1) sel_bad++;
            if (o_valid) valid_at = cyc;
            prev_gate = o_gate;
            if (valid_at < 0) begin
                // Inputs that must not disturb a run in progress.
                i_ring_sel = 2'($urandom);
                i_win      = 4'($urandom);
                i_ack      = 1'($urandom);
                if (noise) i_start = ($urandom_range(0, 7) == 0);
                @(negedge i_clk);
                cyc++;
            end
        end
        i_start = 1'b0;
        i_ack   = 1'b0;

        if (valid_at < 0) begin
            check("valid_timeout", 32'd0, 32'd1);
            return;
        end
        check("clr_cycles", clr_n, 1);
        check("gate_cycles", gate_n, 1 << win);
        check("gate_pulses", gate_rises, 1);
        check("settle_gap", valid_at - fall_at, SETTLE + 1);
        check("ring_sel_busy_hold", sel_bad, 0);

        b = gray_to_bin(gray);
        for (int i = NB - 1; i >= 0; i--) begin
            exp_byte   = 8'(b >> (8 * i));
            hold       = (i == NB - 1) ? hold0 : (rand_hold ? $urandom_range(0, 3) : 0);
            stable_bad = 0;
            if (hold > 0) i_ack = 1'b0;
            repeat (hold) begin
                if (o_valid !== 1'b1 || o_data !== exp_byte) stable_bad++;
                @(negedge i_clk);
            end
            check("stall_stable", stable_bad, 0);
            check("byte_data", o_data, exp_byte);
            check("byte_valid", o_valid, 1);
            check("byte_last", o_last, 32'(i == 0));
            i_ack = 1'b1;
            if (i == 0 && start_last) i_start = 1'b1;
            @(negedge i_clk);
        end
        i_ack   = 1'b0;
        i_start = 1'b0;
        check("busy_after_last", o_busy, 0);
        check("valid_after_last", o_valid, 0);
        @(negedge i_clk);
        check("idle_no_queued_start", o_busy, 0);
    endtask

    // Reset asserted in GATE cycle 100 of a long window.
    task automatic reset_mid_gate();
        int gate_n = 0;
        int cyc    = 0;
        @(negedge i_clk);
        i_start = 1'b1; i_ring_sel = 2'd1; i_win = 4'd8;
        @(negedge i_clk);
        i_start = 1'b0;
        while (gate_n < 100 && cyc < 400) begin
            @(negedge i_clk);
            cyc++;
            if (o_gate) gate_n++;
        end
        check("gate_reached_100", gate_n, 100);
        // Reset wins over a simultaneous start and ack.
        i_rst = 1'b1; i_start = 1'b1; i_ack = 1'b1;
        @(negedge i_clk);
        check("rst_gate", o_gate, 0);
        check("rst_busy", o_busy, 0);
        check("rst_valid", o_valid, 0);
        check("rst_clr", o_clr, 0);
        check("rst_ring_sel", o_ring_sel, 0);
        i_rst = 1'b0; i_start = 1'b0; i_ack = 1'b0;
        @(negedge i_clk);
        check("rst_no_start", o_busy, 0);
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_ring_sel = '0; i_win = '0;
        i_cnt_gray = '0; i_ack = 1'b0;
        repeat (3) @(negedge i_clk);
        check("reset_gate", o_gate, 0);
        check("reset_clr", o_clr, 0);
        check("reset_busy", o_busy, 0);
        check("reset_valid", o_valid, 0);
        check("reset_last", o_last, 0);
        check("reset_data", o_data, 0);
        check("reset_ring_sel", o_ring_sel, 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("idle_busy", o_busy, 0);

        // Shortest window on ring 2.
        run_measure(2'd2, 4'd0, CNT_W'($urandom), 0, 1'b0, 1'b0, 1'b0);
        // Known sample, ack tied high.
        run_measure(2'd0, 4'd2, 16'h0C1A, 0, 1'b0, 1'b0, 1'b0);
        // Ten-cycle stall on the first byte.
        run_measure(2'd1, 4'd1, 16'h0C1A, 10, 1'b0, 1'b0, 1'b0);
        // All-ones result, start on final ack ignored.
        run_measure(2'd3, 4'd3, 16'h8000, 0, 1'b0, 1'b0, 1'b1);
        // Longest window with start pulses and select changes during the run.
        run_measure(2'd3, 4'd15, CNT_W'($urandom), 2, 1'b1, 1'b1, 1'b0);

        reset_mid_gate();
        run_measure(2'd2, 4'd4, 16'h0C1A, 1, 1'b1, 1'b1, 1'b0);

        for (int n = 0; n < 20; n++) begin
            run_measure(2'($urandom), 4'($urandom_range(0, 7)), CNT_W'($urandom),
                        $urandom_range(0, 4), 1'b1, 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ring_meas_seq
